// File: rtl/rgb_fader.sv
// Colour-fade sequencer: steps three 8-bit intensities one code per fade step
// toward a commanded target, paced by a base tick divider and a rate counter.
module rgb_fader #(
  parameter int unsigned TICK_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_r,
  input  logic [7:0] cmd_g,
  input  logic [7:0] cmd_b,
  input  logic [7:0] cmd_rate,
  output logic       en_r,
  output logic       en_g,
  output logic       en_b,
  output logic [7:0] int_r,
  output logic [7:0] int_g,
  output logic [7:0] int_b,
  output logic       busy,
  output logic       done
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  state_t        state;
  logic          first;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    rate_cnt;
  logic [7:0]    rate_q;
  logic [7:0]    tgt_r, tgt_g, tgt_b;

  logic          tick;
  logic          step;
  logic          all_eq;
  logic          nxt_eq;
  logic [7:0]    nxt_r, nxt_g, nxt_b;

  function automatic logic [7:0] toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)
      return cur + 8'd1;
    else if (cur > tgt)
      return cur - 8'd1;
    else
      return cur;
  endfunction

  always_comb begin
    tick   = (tick_cnt == TICK_LAST);
    step   = tick && ((rate_cnt + 8'd1) == rate_q);
    nxt_r  = toward(int_r, tgt_r);
    nxt_g  = toward(int_g, tgt_g);
    nxt_b  = toward(int_b, tgt_b);
    all_eq = (int_r == tgt_r) && (int_g == tgt_g) && (int_b == tgt_b);
    nxt_eq = (nxt_r == tgt_r) && (nxt_g == tgt_g) && (nxt_b == tgt_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      first     <= 1'b0;
      tick_cnt  <= '0;
      rate_cnt  <= '0;
      rate_q    <= '0;
      tgt_r     <= '0;
      tgt_g     <= '0;
      tgt_b     <= '0;
      int_r     <= '0;
      int_g     <= '0;
      int_b     <= '0;
      en_r      <= 1'b0;
      en_g      <= 1'b0;
      en_b      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            tgt_r     <= cmd_r;
            tgt_g     <= cmd_g;
            tgt_b     <= cmd_b;
            rate_q    <= cmd_rate;
            tick_cnt  <= '0;
            rate_cnt  <= '0;
            first     <= 1'b1;
            state     <= FADE;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        FADE: begin
          first <= 1'b0;
          // Rate 0 or nothing to do: jump straight to the target on the first FADE edge.
          if (first && ((rate_q == 8'd0) || all_eq)) begin
            int_r     <= tgt_r;
            int_g     <= tgt_g;
            int_b     <= tgt_b;
            en_r      <= (tgt_r != 8'd0);
            en_g      <= (tgt_g != 8'd0);
            en_b      <= (tgt_b != 8'd0);
            state     <= IDLE;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
              if (step) begin
                rate_cnt <= '0;
                int_r    <= nxt_r;
                int_g    <= nxt_g;
                int_b    <= nxt_b;
                en_r     <= (nxt_r != 8'd0);
                en_g     <= (nxt_g != 8'd0);
                en_b     <= (nxt_b != 8'd0);
                if (nxt_eq) begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                end
              end else begin
                rate_cnt <= rate_cnt + 8'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
